// File: rtl/spi_port_demux_2x.sv
// Routes a 4-line SPI master link to front-end port A or B and returns the routed port's MISO.
// Port changes wait for CSN high and pass through a guard interval with both ports idle.
// Optional macro SPI_PORT_DEMUX_SWITCH_COUNT_EN adds a saturating switch_count output.
module spi_port_demux_2x #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        sel_req,
  input  logic        SCLK_in,
  input  logic        MOSI_in,
  input  logic        CSN_in,
  input  logic        AUX_in,
  output logic        A_SCLK,
  output logic        A_MOSI,
  output logic        A_CSN,
  output logic        A_AUX,
  output logic        B_SCLK,
  output logic        B_MOSI,
  output logic        B_CSN,
  output logic        B_AUX,
  input  logic        A_MISO,
  input  logic        B_MISO,
  output logic        MISO_out,
  output logic        sel_active,
  output logic        busy,
  output logic        drop_err
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
  ,
  output logic [15:0] switch_count
`endif
);

  localparam logic [1:0] StRoute    = 2'd0;
  localparam logic [1:0] StDrain    = 2'd1;
  localparam logic [1:0] StGuard    = 2'd2;
  localparam logic [1:0] StWaitIdle = 2'd3;

  // Line order {SCLK, MOSI, CSN, AUX}; idle keeps CSN deasserted.
  localparam logic [3:0] IdleLines = 4'b0010;
  localparam logic [7:0] GuardLoad = 8'(GUARD_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic                   sel_active_q, sel_active_d;
  logic                   target_q, target_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             a_q, a_d, b_q, b_d;
  logic                   drop_q, drop_d;
  logic                   sel_s;
  logic                   routing;
  logic [3:0]             in_lines;

  assign sel_s    = sync_q[SYNC_STAGES-1];
  assign in_lines = {SCLK_in, MOSI_in, CSN_in, AUX_in};
  assign routing  = (state_q == StRoute) || (state_q == StDrain);
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], sel_req};

  always_comb begin
    state_d      = state_q;
    sel_active_d = sel_active_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    drop_d       = 1'b0;
    case (state_q)
      StRoute: begin
        if (sel_s != sel_active_q) begin
          if (CSN_in) begin
            state_d  = StGuard;
            target_d = sel_s;
            cnt_d    = GuardLoad;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // The request may have been withdrawn while the transaction finished.
        if (CSN_in) begin
          if (sel_s == sel_active_q) begin
            state_d = StRoute;
          end else begin
            state_d  = StGuard;
            target_d = sel_s;
            cnt_d    = GuardLoad;
          end
        end
      end
      StGuard: begin
        if (cnt_q == 8'd0) begin
          sel_active_d = target_q;
          if (CSN_in) begin
            state_d = StRoute;
          end else begin
            state_d = StWaitIdle;
            drop_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWaitIdle: begin
        if (CSN_in) state_d = StRoute;
      end
      default: state_d = StRoute;
    endcase
  end

  always_comb begin
    a_d = IdleLines;
    b_d = IdleLines;
    if (routing) begin
      if (sel_active_q) b_d = in_lines;
      else              a_d = in_lines;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StRoute;
      sel_active_q <= 1'b0;
      target_q     <= 1'b0;
      cnt_q        <= 8'd0;
      sync_q       <= '0;
      a_q          <= IdleLines;
      b_q          <= IdleLines;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_active_q <= sel_active_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      a_q          <= a_d;
      b_q          <= b_d;
      drop_q       <= drop_d;
    end
  end

  assign {A_SCLK, A_MOSI, A_CSN, A_AUX} = a_q;
  assign {B_SCLK, B_MOSI, B_CSN, B_AUX} = b_q;
  assign MISO_out   = routing ? (sel_active_q ? B_MISO : A_MISO) : 1'b0;
  assign sel_active = sel_active_q;
  assign busy       = (state_q != StRoute);
  assign drop_err   = drop_q;

`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
  logic [15:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if ((sel_active_d != sel_active_q) && (sw_cnt_q != 16'hFFFF)) sw_cnt_d = sw_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sw_cnt_q <= 16'd0;
    else       sw_cnt_q <= sw_cnt_d;
  end

  assign switch_count = sw_cnt_q;
`endif

endmodule

// File: tb/tb_spi_port_demux_2x.sv
// Scoreboard-driven bench for spi_port_demux_2x: routing, guarded switches, drain, drops, reset.
// Checks switch_count too when SPI_PORT_DEMUX_SWITCH_COUNT_EN is defined.
module tb_spi_port_demux_2x;
  localparam int unsigned GuardCycles = 4;
  localparam logic [3:0]  Idle        = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel_req = 1'b0;
  logic sclk_in = 1'b0, mosi_in = 1'b0, csn_in = 1'b1, aux_in = 1'b0;
  logic a_sclk, a_mosi, a_csn, a_aux, b_sclk, b_mosi, b_csn, b_aux;
  logic a_miso = 1'b0, b_miso = 1'b0;
  logic miso_out, sel_active, busy, drop_err;
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
  logic [15:0] switch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_switches = 0;
  logic [7:0] sb_q[$];

  spi_port_demux_2x #(
    .GUARD_CYCLES(GuardCycles),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .sel_req   (sel_req),
    .SCLK_in   (sclk_in),
    .MOSI_in   (mosi_in),
    .CSN_in    (csn_in),
    .AUX_in    (aux_in),
    .A_SCLK    (a_sclk),
    .A_MOSI    (a_mosi),
    .A_CSN     (a_csn),
    .A_AUX     (a_aux),
    .B_SCLK    (b_sclk),
    .B_MOSI    (b_mosi),
    .B_CSN     (b_csn),
    .B_AUX     (b_aux),
    .A_MISO    (a_miso),
    .B_MISO    (b_miso),
    .MISO_out  (miso_out),
    .sel_active(sel_active),
    .busy      (busy),
    .drop_err  (drop_err)
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
    ,
    .switch_count(switch_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [3:0] a_lines();
    return {a_sclk, a_mosi, a_csn, a_aux};
  endfunction

  function automatic logic [3:0] b_lines();
    return {b_sclk, b_mosi, b_csn, b_aux};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic m, input logic c, input logic x);
    sclk_in = s; mosi_in = m; csn_in = c; aux_in = x;
  endtask

  // 34-cycle frame: CSN high, 32 cycles low with 16 SCLK pulses, CSN high again.
  task automatic run_frame(input logic port, input int chg_at, input logic chg_val,
                           input int chg2_at, input logic chg2_val, input string tag,
                           output logic busy_end, output logic miso_end);
    logic [3:0] v;
    logic [7:0] exp;
    logic       rs, prev;
    int         edges;
    edges = 0;
    prev  = 1'b0;
    busy_end = 1'bx;
    miso_end = 1'bx;
    for (int i = 0; i < 34; i++) begin
      if (i == chg_at)  sel_req = chg_val;
      if (i == chg2_at) sel_req = chg2_val;
      if (i >= 1 && i <= 32) v = {((i - 1) % 2) == 1, 1'($urandom_range(1)), 1'b0,
                                  1'($urandom_range(1))};
      else                   v = Idle;
      drive(v[3], v[2], v[1], v[0]);
      a_miso = 1'($urandom_range(1));
      b_miso = ~a_miso;
      if (i == 33) begin a_miso = 1'b1; b_miso = 1'b1; end
      sb_q.push_back(port ? {Idle, v} : {v, Idle});
      tick();
      exp = sb_q.pop_front();
      n_checks++;
      if ({a_lines(), b_lines()} !== exp) begin
        n_fail++;
        $display("FAIL %s lines cyc %0d: got %h expected %h", tag, i, {a_lines(), b_lines()}, exp);
      end
      if (i <= 32) begin
        n_checks++;
        if (miso_out !== (port ? b_miso : a_miso)) begin
          n_fail++;
          $display("FAIL %s miso cyc %0d: got %b expected %b", tag, i, miso_out,
                   port ? b_miso : a_miso);
        end
      end
      rs = port ? b_sclk : a_sclk;
      if (rs && !prev) edges++;
      prev = rs;
      if (i == 33) begin busy_end = busy; miso_end = miso_out; end
    end
    n_checks++;
    if (edges != 16) begin
      n_fail++;
      $display("FAIL %s sclk edges: got %0d expected 16", tag, edges);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    a_miso = 1'b1; b_miso = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_lines(), b_lines(), sel_active, busy, drop_err, miso_out} !== {Idle, Idle, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset state: got %h expected %h",
               {a_lines(), b_lines(), sel_active, busy, drop_err, miso_out}, {Idle, Idle, 4'b0001});
    end
    tick(); tick();
    n_checks++;
    if ({a_lines(), b_lines()} !== {Idle, Idle}) begin
      n_fail++;
      $display("FAIL reset held lines: got %h expected %h", {a_lines(), b_lines()}, {Idle, Idle});
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
    n_checks++;
    if (switch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset switch_count: got %0d expected 0", switch_count);
    end
`endif
  endtask

  task automatic test_route_a();
    logic be, me;
    run_frame(1'b0, -1, 1'b0, -1, 1'b0, "route_a", be, me);
    n_checks++;
    if ({be, sel_active} !== 2'b00) begin
      n_fail++;
      $display("FAIL route_a end: got busy/sel %b expected 00", {be, sel_active});
    end
  endtask

  task automatic test_switch_idle();
    int  busy_cnt, first_busy;
    logic be, me;
    busy_cnt = 0;
    first_busy = -1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    sel_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
        n_checks++;
        if ({a_csn, b_csn} !== 2'b11) begin
          n_fail++;
          $display("FAIL guard csn k=%0d: got %b expected 11", k, {a_csn, b_csn});
        end
      end
    end
    exp_switches++;
    n_checks++;
    if (busy_cnt != GuardCycles || first_busy != 2) begin
      n_fail++;
      $display("FAIL guard length: got %0d cycles from %0d expected %0d from 2",
               busy_cnt, first_busy, GuardCycles);
    end
    n_checks++;
    if (sel_active !== 1'b1) begin
      n_fail++;
      $display("FAIL switch to B: got sel_active %b expected 1", sel_active);
    end
    run_frame(1'b1, -1, 1'b0, -1, 1'b0, "frame_b", be, me);
  endtask

  task automatic test_midframe_drain();
    logic be, me;
    int   n;
    run_frame(1'b1, 17, 1'b0, -1, 1'b0, "drain_b", be, me);
    n_checks++;
    if ({be, me} !== 2'b10) begin
      n_fail++;
      $display("FAIL guard after csn rise: got busy/miso %b expected 10", {be, me});
    end
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    exp_switches++;
    n_checks++;
    if (n != GuardCycles || sel_active !== 1'b0) begin
      n_fail++;
      $display("FAIL drain switch: got %0d cycles sel %b expected %0d sel 0", n, sel_active,
               GuardCycles);
    end
  endtask

  task automatic test_drain_return();
    logic be, me;
    run_frame(1'b0, 8, 1'b1, 14, 1'b0, "drain_ret", be, me);
    tick();
    n_checks++;
    if ({be, me, busy, sel_active} !== 4'b0100) begin
      n_fail++;
      $display("FAIL drain return: got %b expected 0100", {be, me, busy, sel_active});
    end
  endtask

  task automatic test_drop();
    int   n, drops, drop_idx, bad_lines, not_busy;
    logic be, me;
    drops = 0; drop_idx = -1; bad_lines = 0; not_busy = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    sel_req = 1'b1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop guard entry: got busy %b expected 1", busy);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(i % 2 == 1, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      tick();
      if ({a_lines(), b_lines()} !== {Idle, Idle}) bad_lines++;
      if (busy !== 1'b1) not_busy++;
      if (drop_err) begin drops++; drop_idx = i; end
    end
    n_checks++;
    if (bad_lines != 0 || not_busy != 0) begin
      n_fail++;
      $display("FAIL drop idle: got %0d active / %0d not-busy cycles expected 0/0", bad_lines,
               not_busy);
    end
    n_checks++;
    if (drops != 1 || drop_idx != 2) begin
      n_fail++;
      $display("FAIL drop_err pulse: got %0d at %0d expected 1 at 2", drops, drop_idx);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    exp_switches++;
    n_checks++;
    if ({busy, sel_active, drop_err} !== 3'b010) begin
      n_fail++;
      $display("FAIL drop exit: got %b expected 010", {busy, sel_active, drop_err});
    end
    run_frame(1'b1, -1, 1'b0, -1, 1'b0, "after_drop", be, me);
  endtask

  task automatic test_miso();
    logic exp;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    a_miso = 1'b1; b_miso = 1'b0;
    sel_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = (k >= 2 + int'(GuardCycles));
      n_checks++;
      if (miso_out !== exp) begin
        n_fail++;
        $display("FAIL miso B->A k=%0d: got %b expected %b", k, miso_out, exp);
      end
    end
    exp_switches++;
    sel_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = (k < 2);
      n_checks++;
      if (miso_out !== exp) begin
        n_fail++;
        $display("FAIL miso A->B k=%0d: got %b expected %b", k, miso_out, exp);
      end
    end
    exp_switches++;
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 10; i++) begin
      drive(i % 2 == 1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    n_checks++;
    if (b_lines() !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre-reset frame on B: got %h expected d", b_lines());
    end
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
    n_checks++;
    if (switch_count !== 16'(exp_switches)) begin
      n_fail++;
      $display("FAIL switch_count pre-reset: got %0d expected %0d", switch_count, exp_switches);
    end
`endif
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_lines(), b_lines(), sel_active, busy, miso_out} !== {Idle, Idle, 3'b001}) begin
      n_fail++;
      $display("FAIL reset mid-frame: got %h expected %h",
               {a_lines(), b_lines(), sel_active, busy, miso_out}, {Idle, Idle, 3'b001});
    end
    sel_req = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    exp_switches = 0;
    tick();
  endtask

`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
  task automatic test_switch_count();
    logic be, me;
    int   n;
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      sel_req = ~sel_req;
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      while (busy && n < 30) begin tick(); n++; end
      exp_switches++;
    end
    n_checks++;
    if (switch_count !== 16'(exp_switches) || sel_active !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_count 3 switches: got %0d sel %b expected %0d sel 1", switch_count,
               sel_active, exp_switches);
    end
    run_frame(1'b1, 8, 1'b0, 14, 1'b1, "count_drain_ret", be, me);
    tick();
    n_checks++;
    if (switch_count !== 16'(exp_switches)) begin
      n_fail++;
      $display("FAIL switch_count drain return: got %0d expected %0d", switch_count, exp_switches);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_route_a();
    test_switch_idle();
    test_midframe_drain();
    test_drain_return();
    test_drop();
    test_miso();
    test_reset_mid_frame();
`ifdef SPI_PORT_DEMUX_SWITCH_COUNT_EN
    test_switch_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
